// File: rtl/wishbone_bitstream_loader.sv
// wishbone_bitstream_loader: Wishbone classic master streaming 32-bit words from a
// valid/ready source as single-beat writes to sequential addresses.
module wishbone_bitstream_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_STRIDE = 32'd4,
  parameter int          CNT_W       = 16,
  parameter int          TIMEOUT     = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] word_count_i,
  input  logic             word_valid_i,
  input  logic [31:0]      word_data_i,
  output logic             word_ready_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_addr_o,
  output logic [31:0]      wbm_data_o,
  input  logic             wbm_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CNT_W-1:0] words_done_o
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, DONE, ERR} state_t;
  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [TW-1:0]    tmo;
  assign word_ready_o = (state == FETCH) && !abort_i;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      remaining    <= '0;
      tmo          <= '0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_sel_o    <= 4'h0;
      wbm_addr_o   <= '0;
      wbm_data_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      words_done_o <= '0;
    end else if (abort_i) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start_i) begin
          remaining    <= word_count_i;
          wbm_addr_o   <= BASE_ADDR;
          words_done_o <= '0;
          error_o      <= 1'b0;
          done_o       <= word_count_i == '0;
          busy_o       <= word_count_i != '0;
          state        <= word_count_i == '0 ? DONE : FETCH;
        end
        FETCH: if (word_valid_i) begin
          wbm_data_o <= word_data_i;
          wbm_cyc_o  <= 1'b1;
          wbm_stb_o  <= 1'b1;
          wbm_we_o   <= 1'b1;
          wbm_sel_o  <= 4'hF;
          tmo        <= '0;
          state      <= WRITE;
        end
        WRITE: if (wbm_ack_i) begin
          // an ack in the expiry cycle still completes the write
          wbm_cyc_o    <= 1'b0;
          wbm_stb_o    <= 1'b0;
          wbm_we_o     <= 1'b0;
          wbm_sel_o    <= 4'h0;
          words_done_o <= words_done_o + CNT_W'(1);
          remaining    <= remaining - CNT_W'(1);
          wbm_addr_o   <= wbm_addr_o + ADDR_STRIDE;
          done_o       <= remaining == CNT_W'(1);
          busy_o       <= remaining != CNT_W'(1);
          state        <= remaining == CNT_W'(1) ? DONE : FETCH;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          wbm_sel_o <= 4'h0;
          error_o   <= 1'b1;
          busy_o    <= 1'b0;
          state     <= ERR;
        end else begin
          tmo <= tmo + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wishbone_bitstream_loader.sv
// tb_wishbone_bitstream_loader: table-driven and randomized checks of the loader
// against a queue-based model of the expected write stream and a wait-state slave.
module tb_wishbone_bitstream_loader;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int TMO = 8;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, valid = 1'b0;
  logic [15:0] word_count = '0;
  logic [31:0] wdata = '0;
  logic        ready, cyc, stb, we, busy, done, err;
  logic [3:0]  sel;
  logic [31:0] addr, data;
  logic [15:0] words_done;
  logic        slv_ack = 1'b0, stray_ack = 1'b0;
  int          slv_waits = 0, ws = 0;
  logic [31:0] hold_a, hold_d;
  logic [31:0] wr_a[$], wr_d[$];
  int          lens[$];
  int          n_chk = 0, n_fail = 0;

  wishbone_bitstream_loader #(.BASE_ADDR(BASE), .ADDR_STRIDE(32'd4), .CNT_W(16), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
    .word_count_i(word_count), .word_valid_i(valid), .word_data_i(wdata),
    .word_ready_o(ready), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_sel_o(sel), .wbm_addr_o(addr), .wbm_data_o(data),
    .wbm_ack_i(slv_ack | stray_ack), .busy_o(busy), .done_o(done),
    .error_o(err), .words_done_o(words_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // slave with programmable wait states; logs every acked write and strobe length
  always @(negedge clk) begin
    if (stb) begin
      if (ws == 0) begin
        hold_a = addr;
        hold_d = data;
      end else begin
        chk("stb_hold", {addr, data}, {hold_a, hold_d});
      end
      chk("we_sel", {59'd0, we, sel}, {59'd0, 1'b1, 4'hF});
      slv_ack = (ws == slv_waits);
      if (slv_ack) begin
        wr_a.push_back(addr);
        wr_d.push_back(data);
      end
      ws++;
    end else begin
      if (ws > 0) lens.push_back(ws);
      slv_ack = 1'b0;
      ws = 0;
    end
  end

  task automatic run_load(input int count, input int waits, input int gap,
                          input bit x_done, input bit x_err, input int x_words);
    logic [31:0] exp_q[$];
    int idx = 0, since = 0, cyc_n = 0, n_len;
    wr_a.delete();
    wr_d.delete();
    lens.delete();
    slv_waits = waits;
    for (int i = 0; i < count; i++) exp_q.push_back($urandom);
    @(negedge clk);
    start = 1'b1;
    word_count = 16'(count);
    @(negedge clk);
    start = 1'b0;
    word_count = 16'($urandom);
    chk("start_clears_err", {63'd0, err}, 64'd0);
    chk("zero_count_done", {63'd0, done}, {63'd0, count == 0});
    while (!(done || err) && cyc_n < 3000) begin
      if (ready) begin
        if (idx < count && since >= gap) begin
          valid = 1'b1;
          wdata = exp_q[idx];
          idx++;
          since = 0;
        end else begin
          valid = 1'b0;
          since++;
          chk("bus_idle", {62'd0, cyc, stb}, 64'd0);
        end
      end else begin
        valid = 1'($urandom);
        wdata = $urandom;
      end
      @(negedge clk);
      cyc_n++;
    end
    valid = 1'b0;
    chk("load_budget", {63'd0, cyc_n < 3000}, 64'd1);
    @(negedge clk);
    #1;
    chk("done", {63'd0, done}, {63'd0, x_done});
    chk("error", {63'd0, err}, {63'd0, x_err});
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("words_done", {48'd0, words_done}, 64'(x_words));
    chk("n_writes", 64'(wr_a.size()), 64'(x_words));
    for (int i = 0; i < wr_a.size() && i < x_words; i++) begin
      chk("wr_addr", {32'd0, wr_a[i]}, {32'd0, BASE + 32'(4 * i)});
      chk("wr_data", {32'd0, wr_d[i]}, {32'd0, exp_q[i]});
    end
    n_len = x_words + (x_err ? 1 : 0);
    chk("n_strobes", 64'(lens.size()), 64'(n_len));
    for (int i = 0; i < lens.size() && i < n_len; i++)
      chk("stb_len", 64'(lens[i]), 64'(i < x_words ? waits + 1 : TMO));
  endtask

  typedef struct {
    int count;
    int waits;
    int gap;
    bit x_done;
    bit x_err;
    int x_words;
  } vec_t;

  initial begin
    vec_t vecs[7];
    vecs[0] = '{3, 0, 0, 1'b1, 1'b0, 3};
    vecs[1] = '{0, 0, 0, 1'b1, 1'b0, 0};
    vecs[2] = '{2, 3, 5, 1'b1, 1'b0, 2};
    vecs[3] = '{1, 8, 0, 1'b0, 1'b1, 0};
    vecs[4] = '{2, 0, 0, 1'b1, 1'b0, 2};
    vecs[5] = '{2, 7, 1, 1'b1, 1'b0, 2};
    vecs[6] = '{3, 20, 0, 1'b0, 1'b1, 0};
    @(negedge clk);
    chk("reset_bus", {cyc, stb, we, sel, addr[26:0], ready}, 64'd0);
    chk("reset_status", {addr[31:27], data, busy, done, err, words_done}, 64'd0);
    rst = 1'b0;
    foreach (vecs[i])
      run_load(vecs[i].count, vecs[i].waits, vecs[i].gap,
               vecs[i].x_done, vecs[i].x_err, vecs[i].x_words);
    for (int r = 0; r < 20; r++) begin
      int c, w, g;
      bit fail;
      c = $urandom_range(0, 6);
      w = $urandom_range(0, 10);
      g = $urandom_range(0, 3);
      fail = c > 0 && w >= TMO;
      run_load(c, w, g, !fail, fail, fail ? 0 : c);
    end
    // abort during the second of four writes
    slv_waits = 0;
    @(negedge clk);
    start = 1'b1;
    word_count = 16'd4;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    wdata = $urandom;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    slv_waits = 100;
    valid = 1'b1;
    wdata = $urandom;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_stb", {63'd0, stb}, 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_bus", {62'd0, cyc, stb}, 64'd0);
    chk("abort_status", {61'd0, busy, done, err}, 64'd0);
    chk("abort_words", {48'd0, words_done}, 64'd1);
    start = 1'b1;
    abort = 1'b1;
    word_count = 16'd2;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", {61'd0, busy, ready, cyc}, 64'd0);
    chk("abort_start_words", {48'd0, words_done}, 64'd1);
    // asynchronous reset while a write is outstanding
    @(negedge clk);
    start = 1'b1;
    word_count = 16'd2;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    wdata = $urandom;
    @(negedge clk);
    valid = 1'b0;
    chk("rst_pre_stb", {63'd0, stb}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_bus", {cyc, stb, we, sel, addr[26:0], ready}, 64'd0);
    chk("rst_async_status", {addr[31:27], data, busy, done, err, words_done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // acks outside a write must not count
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    chk("stray_ack", {47'd0, words_done, busy}, 64'd0);
    run_load(2, 1, 0, 1'b1, 1'b0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
